// File: rtl/snake_vga_pkg.sv
// Shared constants for the snake VGA scan-out: framebuffer geometry,
// 640x480@60 timing, and the write-side FSM encoding.
package snake_vga_pkg;

  localparam int XSCREEN  = 160;
  localparam int YSCREEN  = 120;
  localparam int FB_DEPTH = XSCREEN * YSCREEN;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // row*160 + col as two shifts and adds, so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] col,
                                                input logic [6:0] row);
    return {1'b0, row, 7'b0} + {3'b0, row, 5'b0} + {7'b0, col};
  endfunction

endpackage

// File: rtl/snake_fb_ram.sv
// 160x120x3 framebuffer: one write port, one registered read port, both on
// the system clock, written so it maps onto block RAM.
module snake_fb_ram
  import snake_vga_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  input  logic                re,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [COLOUR_W-1:0] rd_data
);

  logic [COLOUR_W-1:0] mem [FB_DEPTH];

  // NOTE: memories get no reset -- a reset would turn the block RAM into
  // flops; the post-reset clear pass initialises the contents instead.
  // A same-address read and write returns the old word (read-first).
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/snake_vga_scanout.sv
// Pixel-write receiver and 640x480@60 VGA scan-out of a 160x120 framebuffer,
// each logical pixel shown as a 4x4 block; clears the buffer after reset.
module snake_vga_scanout
  import snake_vga_pkg::*;
#(
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot,
  output logic                busy,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC_N,
  output logic                VGA_CLK
);

  logic [0:0]          state;
  logic [ADDR_W-1:0]   clear_addr;
  logic                plot_ok;
  logic                we;
  logic [ADDR_W-1:0]   wr_addr;
  logic [COLOUR_W-1:0] wr_data;

  logic                pe;
  logic [9:0]          hcount;
  logic [9:0]          vcount;
  logic                visible;
  logic                hs_n;
  logic                vs_n;
  logic [ADDR_W-1:0]   rd_addr;
  logic [COLOUR_W-1:0] pix;
  logic                hs_q;
  logic                vs_q;
  logic                blank_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_CLEAR;
      clear_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clear_addr == ADDR_W'(FB_DEPTH - 1)) begin
        state      <= ST_RUN;
        clear_addr <= '0;
      end else begin
        clear_addr <= clear_addr + 1'b1;
      end
    end
  end

  assign busy = (state == ST_CLEAR);

  // Out-of-range plots are dropped rather than wrapped into the next row.
  assign plot_ok = plot && (x < 8'(XSCREEN)) && (y < 7'(YSCREEN));
  assign we      = busy | plot_ok;
  assign wr_addr = busy ? clear_addr : fb_addr(x, y);
  assign wr_data = busy ? BG_COLOUR : colour;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pe     <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pe <= ~pe;
      if (pe) begin
        if (hcount == 10'(H_TOTAL - 1)) begin
          hcount <= '0;
          vcount <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  assign visible = (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));
  assign hs_n = !((hcount >= 10'(H_VISIBLE + H_FRONT)) &&
                  (hcount <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign vs_n = !((vcount >= 10'(V_VISIBLE + V_FRONT)) &&
                  (vcount <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
  assign rd_addr = visible ? fb_addr(hcount[9:2], vcount[8:2]) : '0;

  snake_fb_ram u_fb (
    .clk     (CLOCK_50),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (pe),
    .rd_addr (rd_addr),
    .rd_data (pix)
  );

  // Sync and blank are delayed one pixel tick to line up with the RAM read.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else if (pe) begin
      hs_q    <= hs_n;
      vs_q    <= vs_n;
      blank_q <= visible;
    end
  end

  assign VGA_R       = {8{blank_q & pix[2]}};
  assign VGA_G       = {8{blank_q & pix[1]}};
  assign VGA_B       = {8{blank_q & pix[0]}};
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pe;

endmodule

// File: doc/snake_vga_scanout.md
# snake_vga_scanout

Receiving end of the game's pixel-write interface (x, y, colour, plot). It stores plotted pixels in a 160x120, 3-bit framebuffer. It scans that buffer out as 640x480@60 Hz VGA, replicating each logical pixel 4x4. It sits between the game FSMs (drawing, erasing, apple) and the DE1-SoC VGA DAC pins. After reset it clears the buffer to a background colour before it accepts any plot.

## Interface
- BG_COLOUR, 3'b000, colour written to every framebuffer cell during the post-reset clear.
- XSCREEN, 160, logical width in pixels.
- YSCREEN, 120, logical height in pixels.
- CLOCK_50  in  1  system clock, 50 MHz; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- x  in  8  write column.
- y  in  7  write row.
- colour  in  3  write colour {R,G,B}.
- plot  in  1  write strobe; one write per cycle it is high.
- busy  out  1  high while the post-reset clear runs; plots are dropped while high.
- VGA_R, VGA_G, VGA_B  out  8 each  colour bit expanded: 1 -> 8'hFF, 0 -> 8'h00.
- VGA_HS, VGA_VS  out  1 each  sync, active-low.
- VGA_BLANK_N  out  1  high in the visible region.
- VGA_SYNC_N  out  1  tied 0.
- VGA_CLK  out  1  25 MHz pixel clock (CLOCK_50 / 2).

## Operation
- Reset (asynchronous) values:
  - outputs: VGA_R/G/B = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0, VGA_CLK = 0, busy = 1;
  - internal: h/v counters = 0, clear address = 0, FSM = CLEAR.
- The framebuffer contents are not reset; the CLEAR state overwrites them.
- Write FSM states:
  - CLEAR: each cycle writes BG_COLOUR at the clear address, then increments the address. After writing address 19199, the FSM goes to RUN and busy drops.
  - RUN: terminal state; left only by reset.
- Write address = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x.
  - In RUN, a cycle with plot=1, x<160 and y<120 writes colour at that address.
  - A plot with x>=160 or y>=120 is ignored; there is no wrap-around into the next row.
  - Plots arriving while busy=1 are dropped, not queued.
- Pixel enable pe toggles every CLOCK_50 cycle; VGA_CLK mirrors pe. All scan logic advances only on cycles where pe=1.
- hcount runs 0..799. Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- vcount runs 0..524 and increments when hcount wraps. Visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Read address = (vcount>>2)*160 + (hcount>>2). It is only used when visible.
- Simultaneous write and scan-read of the same cell: the read returns the old data; the new value appears on the next frame.

## Timing
- Write latency: a plot in cycle t is visible to the scan read from cycle t+1.
- Scan pipeline: 1 pe-stage.
  - RAM data, HS, VS and BLANK_N are registered together on pe.
  - The pins therefore lag the counters by exactly one pixel tick (2 CLOCK_50 cycles) and stay mutually aligned.
- Outside the visible region, VGA_R/G/B are forced to 0.
- Line = 1600 CLOCK_50 cycles; frame = 840000 CLOCK_50 cycles.
- HS low for 192 CLOCK_50 cycles; VS low for 2 lines (3200 cycles).
- Clear takes 19200 cycles from reset release. busy deasserts at cycle 19200 and the first plot is accepted in that cycle.
- Reset mid-frame or mid-clear: outputs return to reset values immediately; the clear restarts from address 0.

## Structure
- Package snake_vga_pkg holds:
  - XSCREEN, YSCREEN, FB_DEPTH = 19200, address width 15;
  - the h/v timing constants (visible, front, sync, back, total);
  - the colour width, 3;
  - the FSM state encoding CLEAR/RUN.
- Sub-module snake_fb_ram: simple dual-port RAM.
  - One write port, one registered read port; both on CLOCK_50.
  - Read enable = pe.
  - Inferable as M10K.
- Top level holds the clear FSM, the write arbitration (clear address vs x/y) and the scan counters/pipeline.

## Test plan
- Reset: hold resetn=0 -> all outputs equal the reset values listed above. Release -> busy high for exactly 19200 cycles, then 0.
- Clear with BG_COLOUR=3'b010, no plots -> every visible pixel shows R=0, G=FF, B=0 for a full frame.
- After clear, plot (0,0) colour 3'b100 for one cycle -> next frame: R=FF only at hcount 0..3, vcount 0..3 (pins one tick later). Adjacent pixel (4,0) stays background.
- Plot x=160, y=10 and x=5, y=120 -> framebuffer unchanged. Plot (159,119) -> lower-right 4x4 block coloured.
- Sync check over 2 frames:
  - HS low 192 cycles every 1600 cycles;
  - VS low 3200 cycles every 840000 cycles;
  - BLANK_N high 1280 cycles per visible line.
- Plot during busy, then a reset asserted mid-clear at cycle 5000 -> the dropped plot never appears; busy stays high until 19200 cycles after the second release.
